// File: rtl/addr_dec_resp_mux_varlat.sv
// addr_dec_resp_mux_varlat
// Decodes one master request onto NumSlave slave ports and routes
// variable-latency slave responses back to the master in issue order.
// An in-order FIFO of slave indices records which slave owes the next
// response; only the slave at the FIFO head may return data.
//
// Ports
//   clk_i, rst_ni         clock, synchronous active-low reset
//   req_i, we_i           master request / write enable
//   sel_i                 target slave index
//   data_i                request payload
//   gnt_o                 grant back to master
//   rvld_o, rdata_o       in-order response to master
//   outst_o               outstanding response-bearing transactions
//   err_o                 registered pulse: response from a slave not at head
//   req_o                 one-hot per-slave request
//   gnt_i                 per-slave grants
//   data_o                payload broadcast to all slaves (flattened)
//   rvalid_i, rdata_i     per-slave responses (rdata_i flattened)

module addr_dec_resp_mux_varlat #(
    parameter int NumSlave      = 32,
    parameter int ReqDataWidth  = 32,
    parameter int RespDataWidth = 32,
    parameter int MaxTrans      = 4,
    parameter bit WriteResp     = 1'b0,
    localparam int SelW = (NumSlave > 1) ? $clog2(NumSlave) : 1,
    localparam int CntW = $clog2(MaxTrans + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              req_i,
    input  logic                              we_i,
    input  logic [SelW-1:0]                   sel_i,
    input  logic [ReqDataWidth-1:0]           data_i,
    output logic                              gnt_o,
    output logic                              rvld_o,
    output logic [RespDataWidth-1:0]          rdata_o,
    output logic [CntW-1:0]                   outst_o,
    output logic                              err_o,
    output logic [NumSlave-1:0]               req_o,
    input  logic [NumSlave-1:0]               gnt_i,
    output logic [NumSlave*ReqDataWidth-1:0]  data_o,
    input  logic [NumSlave-1:0]               rvalid_i,
    input  logic [NumSlave*RespDataWidth-1:0] rdata_i
);

    localparam int PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

    logic [SelW-1:0]     fifo_q [MaxTrans];
    logic [PtrW-1:0]     head_q, tail_q;
    logic [CntW-1:0]     count_q;
    logic                err_q;

    logic                full, empty;
    logic [SelW-1:0]     head_sel;
    logic [NumSlave-1:0] head_oh;
    logic                push, pop, stray;

    // Pointers wrap explicitly so MaxTrans need not be a power of two.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTrans - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full     = (count_q == CntW'(MaxTrans));
    assign empty    = (count_q == '0);
    assign head_sel = fifo_q[head_q];

    assign data_o   = {NumSlave{data_i}};

    // A full FIFO blocks new requests outright, even when a pop happens in
    // the same cycle, so the grant path never depends on response timing.
    always_comb begin
        req_o   = '0;
        head_oh = '0;
        for (int i = 0; i < NumSlave; i++) begin
            if (sel_i == SelW'(i)) req_o[i] = req_i & ~full;
            head_oh[i] = (head_sel == SelW'(i));
        end
    end

    assign gnt_o  = |(gnt_i & req_o);
    assign rvld_o = ~empty & |(rvalid_i & head_oh);

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NumSlave; i++) begin
            if (rvld_o && head_oh[i]) rdata_o = rdata_i[i*RespDataWidth +: RespDataWidth];
        end
    end

    assign push  = gnt_o & (~we_i | WriteResp);
    assign pop   = rvld_o;
    assign stray = empty ? |rvalid_i : |(rvalid_i & ~head_oh);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= stray;
            if (push) tail_q <= ptr_inc(tail_q);
            if (pop)  head_q <= ptr_inc(head_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset: entries are only read below count_q.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[tail_q] <= sel_i;
    end

    assign outst_o = count_q;
    assign err_o   = err_q;

endmodule

// File: doc/addr_dec_resp_mux_varlat.md
ADDR_DEC_RESP_MUX_VARLAT -- requirements
Module: addr_dec_resp_mux_varlat

Interface
REQ-001 Parameter NumSlave, default 32, number of slave ports (>=2).
REQ-002 Parameter ReqDataWidth, default 32, request payload width.
REQ-003 Parameter RespDataWidth, default 32, response payload width.
REQ-004 Parameter MaxTrans, default 4, maximum outstanding response-bearing transactions (>=1).
REQ-005 Parameter WriteResp, default 0: 1 = writes return a response; 0 = only reads do.
REQ-006 Derived: SelW = max(1, clog2(NumSlave)); CntW = clog2(MaxTrans+1).
REQ-007 clk_i  in  1  clock; one clock domain, all logic on rising edge.
REQ-008 rst_ni  in  1  reset, synchronous, active-low.
REQ-009 req_i  in  1  master request.
REQ-010 we_i  in  1  master write enable (1 = write).
REQ-011 sel_i  in  SelW  target slave index.
REQ-012 data_i  in  ReqDataWidth  request payload.
REQ-013 gnt_o  out  1  grant to master.
REQ-014 rvld_o  out  1  response valid to master.
REQ-015 rdata_o  out  RespDataWidth  response data to master.
REQ-016 outst_o  out  CntW  current outstanding count.
REQ-017 err_o  out  1  registered protocol-error pulse.
REQ-018 req_o  out  NumSlave  decoded per-slave requests.
REQ-019 gnt_i  in  NumSlave  per-slave grants.
REQ-020 data_o  out  NumSlave x ReqDataWidth  broadcast payload.
REQ-021 rvalid_i  in  NumSlave  per-slave response valid (variable latency, >=1 cycle after grant).
REQ-022 rdata_i  in  NumSlave x RespDataWidth  per-slave response data.

Function
REQ-023 Block SHALL hold an in-order FIFO of slave indices, depth MaxTrans, head/tail pointers wrapping modulo MaxTrans, plus registered count.
REQ-024 full = (count == MaxTrans); empty = (count == 0); both from registered count only.
REQ-025 req_o SHALL be all-zero except bit sel_i = req_i & ~full.
REQ-026 data_o SHALL replicate data_i to every slave unconditionally.
REQ-027 gnt_o SHALL equal |(gnt_i & req_o); grants on non-requested slaves ignored.
REQ-028 Push: when gnt_o & (~we_i | WriteResp), sel_i written at tail, tail advances.
REQ-029 Granted writes with WriteResp=0 SHALL not push and never produce rvld_o.
REQ-030 rvld_o = ~empty & rvalid_i[head entry]; combinational, zero added latency.
REQ-031 rdata_o = rdata_i[head entry] when rvld_o, else all-zero.
REQ-032 Pop: when rvld_o, head advances.
REQ-033 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-034 When full, new requests stall even if a pop occurs same cycle (no same-cycle bypass).
REQ-035 When empty, any rvalid_i is ignored for rvld_o; entry pushed in cycle N is poppable no earlier than N+1.
REQ-036 err_o SHALL pulse one cycle after any cycle where rvalid_i has a bit set other than the head entry's bit, or any bit set while empty.
REQ-037 outst_o SHALL equal registered count.

Reset
REQ-038 On rst_ni low at a clock edge: count, head, tail, err_o SHALL go to 0; FIFO contents don't-care.
REQ-039 Reset mid-operation SHALL discard outstanding entries; responses arriving after reset release raise err_o.
REQ-040 After reset: req_o=0 unless req_i, gnt_o=0 unless granted, rvld_o=0, rdata_o=0, outst_o=0.

Verification
REQ-041 Single read, NumSlave=4, sel_i=2, gnt_i[2]=1, rvalid_i[2] 3 cycles later with 0xDEADBEEF -> rvld_o=1, rdata_o=0xDEADBEEF that cycle, outst_o 1 then 0.
REQ-042 MaxTrans=4, 5 back-to-back reads all granted -> 5th has req_o=0, gnt_o=0, outst_o=4; released cycle after first response pops.
REQ-043 Reads to slaves 1 then 3; rvalid_i[3] asserted before rvalid_i[1] -> no rvld_o, err_o=1 next cycle; later rvalid_i[1] -> rvld_o with slave 1 data.
REQ-044 WriteResp=0, granted write to slave 0 -> outst_o stays 0, rvalid_i[0] afterwards -> err_o pulse, rvld_o=0.
REQ-045 Push and pop same cycle with outst_o=2 -> outst_o stays 2, response order preserved through pointer wrap (>=2*MaxTrans transactions).
REQ-046 rst_ni low with outst_o=3 -> next cycle outst_o=0, rvld_o=0, err_o=0.
